pipe_stall_ctrl: RTL and testbench

- Consumer end of the hazard unit's insert_nop interface: turns hazard, branch/jump-taken, createdump (halt) and data-memory-busy requests into per-stage write enables, flushes and bubble injection for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Owns the halt drain sequence, a saturating stall-cycle counter and a stall-deadlock watchdog.
- Sits beside the hazard unit at processor top level; drives the enable/NOP pins of every pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Imported by the controller and its testbench.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int MAX_STALL_DEF    = 3;
    localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Synchronous clear, asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline enable/flush/bubble control with halt drain,
// stall-cycle counter and stall-deadlock watchdog.
import pipe_ctrl_pkg::*;

module pipe_stall_ctrl #(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int MAX_STALL    = MAX_STALL_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             insert_nop,
    input  logic             br_j_taken,
    input  logic             halt_dec,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             de_nop,
    output logic             pipe_we,
    output logic             halted,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DW = $clog2(DRAIN_CYCLES) + 1;
    localparam int WW = $clog2(MAX_STALL) + 1;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic [WW-1:0] wd_cnt;
    logic          halt_go;
    logic          stall_inc;

    always_comb begin
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        fd_flush = 1'b0;
        de_nop   = 1'b0;
        pipe_we  = 1'b0;
        halt_go  = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_busy) begin
                        pc_we = 1'b0;
                    end else if (insert_nop) begin
                        de_nop  = 1'b1;
                        pipe_we = 1'b1;
                    end else if (br_j_taken) begin
                        pc_we    = 1'b1;
                        fd_we    = 1'b1;
                        fd_flush = 1'b1;
                        pipe_we  = 1'b1;
                    end else if (halt_dec) begin
                        fd_flush = 1'b1;
                        pipe_we  = 1'b1;
                        halt_go  = 1'b1;
                    end else begin
                        pc_we   = 1'b1;
                        fd_we   = 1'b1;
                        pipe_we = 1'b1;
                    end
                end
                DRAIN: begin
                    fd_we    = 1'b1;
                    fd_flush = 1'b1;
                    pipe_we  = !mem_busy;
                end
                default: pc_we = 1'b0;
            endcase
        end
    end

    // only real hazard/memory stalls count; halt acceptance does not
    assign stall_inc = (state == RUN) && (mem_busy || insert_nop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_err <= 1'b0;
            drain_cnt <= '0;
            wd_cnt    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!mem_busy) begin
                        if (insert_nop) begin
                            if (wd_cnt == WW'(MAX_STALL)) begin
                                stall_err <= 1'b1;
                            end else begin
                                wd_cnt <= wd_cnt + 1'b1;
                            end
                        end else begin
                            wd_cnt <= '0;
                        end
                    end
                    if (halt_go) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_cnt == '0) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .clr (1'b0),
        .q   (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: enables, watchdog, drain,
// stall counter saturation and reset behaviour.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        insert_nop;
    logic        br_j_taken;
    logic        halt_dec;
    logic        mem_busy;
    logic        pc_we;
    logic        fd_we;
    logic        fd_flush;
    logic        de_nop;
    logic        pipe_we;
    logic        halted;
    logic        stall_err;
    logic [15:0] stall_cycles;
    logic [4:0]  en;

    int tests;
    int failed;

    pipe_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .insert_nop   (insert_nop),
        .br_j_taken   (br_j_taken),
        .halt_dec     (halt_dec),
        .mem_busy     (mem_busy),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .fd_flush     (fd_flush),
        .de_nop       (de_nop),
        .pipe_we      (pipe_we),
        .halted       (halted),
        .stall_err    (stall_err),
        .stall_cycles (stall_cycles)
    );

    // {pc_we, fd_we, fd_flush, de_nop, pipe_we}
    assign en = {pc_we, fd_we, fd_flush, de_nop, pipe_we};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic n, input logic b,
                          input logic h, input logic m);
        insert_nop = n;
        br_j_taken = b;
        halt_dec   = h;
        mem_busy   = m;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 1, 1, 0);
        #2;
        tests++;
        if (en !== 5'b00000) begin
            failed++;
            $display("FAIL reset_en got %b want 00000", en);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({halted, stall_err, stall_cycles} !== 18'd0) begin
            failed++;
            $display("FAIL reset_regs got h=%b e=%b c=%h want 0",
                     halted, stall_err, stall_cycles);
        end
        set_in(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        do_rst();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0);
            #1;
            tests++;
            if (en !== 5'b11001) begin
                failed++;
                $display("FAIL idle_en[%0d] got %b want 11001", i, en);
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if (stall_cycles !== 16'd0) begin
            failed++;
            $display("FAIL idle_cnt got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_stall_branch();
        do_rst();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 0, 0);
            #1;
            tests++;
            if (en !== 5'b00011) begin
                failed++;
                $display("FAIL stall_en[%0d] got %b want 00011", i, en);
            end
            @(posedge clk);
            #1;
        end
        set_in(0, 1, 1, 0);
        #1;
        tests++;
        if (en !== 5'b11101) begin
            failed++;
            $display("FAIL branch_en got %b want 11101", en);
        end
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0);
        tests++;
        if (stall_cycles !== 16'd2 || stall_err !== 1'b0) begin
            failed++;
            $display("FAIL stall_cnt got c=%0d e=%b want c=2 e=0",
                     stall_cycles, stall_err);
        end
    endtask

    task automatic test_watchdog();
        do_rst();
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 0, 0, 0);
            @(posedge clk);
            #1;
            tests++;
            if (stall_err !== (i == 4)) begin
                failed++;
                $display("FAIL wd_err[%0d] got %b want %b",
                         i, stall_err, (i == 4));
            end
        end
        set_in(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (stall_err !== 1'b1 || en !== 5'b11001) begin
            failed++;
            $display("FAIL wd_sticky got e=%b en=%b want e=1 en=11001",
                     stall_err, en);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (stall_err !== 1'b0) begin
            failed++;
            $display("FAIL wd_rst got %b want 0", stall_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_halt();
        logic busy;
        do_rst();
        set_in(0, 0, 1, 0);
        #1;
        tests++;
        if (en !== 5'b00101) begin
            failed++;
            $display("FAIL halt_acc_en got %b want 00101", en);
        end
        @(posedge clk);
        #1;
        for (int k = 1; k <= 6; k++) begin
            busy = (k == 2) || (k == 3);
            set_in(1, 1, 0, busy);
            #1;
            tests++;
            if (en !== {4'b0110, !busy}) begin
                failed++;
                $display("FAIL drain_en[%0d] got %b want %b",
                         k, en, {4'b0110, !busy});
            end
            @(posedge clk);
            #1;
            tests++;
            if (halted !== (k == 6)) begin
                failed++;
                $display("FAIL drain_halted[%0d] got %b want %b",
                         k, halted, (k == 6));
            end
        end
        set_in(0, 0, 0, 0);
        #1;
        tests++;
        if (en !== 5'b00000) begin
            failed++;
            $display("FAIL halted_en got %b want 00000", en);
        end
        set_in(1, 1, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (en !== 5'b00000 || halted !== 1'b1) begin
            failed++;
            $display("FAIL halted_hold got en=%b h=%b want 00000 h=1",
                     en, halted);
        end
        set_in(0, 0, 0, 0);
    endtask

    task automatic test_busy_priority();
        do_rst();
        set_in(1, 0, 0, 0);
        @(posedge clk);
        #1;
        set_in(1, 1, 1, 1);
        #1;
        tests++;
        if (en !== 5'b00000) begin
            failed++;
            $display("FAIL busy_en got %b want 00000", en);
        end
        @(posedge clk);
        #1;
        tests++;
        if (stall_cycles !== 16'd2) begin
            failed++;
            $display("FAIL busy_cnt got %0d want 2", stall_cycles);
        end
        set_in(1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (stall_err !== 1'b0) begin
            failed++;
            $display("FAIL busy_wd_hold got %b want 0", stall_err);
        end
        @(posedge clk);
        #1;
        tests++;
        if (stall_err !== 1'b1) begin
            failed++;
            $display("FAIL busy_wd_fire got %b want 1", stall_err);
        end
        set_in(0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        do_rst();
        set_in(0, 0, 0, 1);
        repeat (65534) @(posedge clk);
        #1;
        tests++;
        if (stall_cycles !== 16'hFFFE) begin
            failed++;
            $display("FAIL sat_pre got %h want fffe", stall_cycles);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (stall_cycles !== 16'hFFFF) begin
            failed++;
            $display("FAIL sat_top got %h want ffff", stall_cycles);
        end
        set_in(1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (stall_cycles !== 16'hFFFF) begin
            failed++;
            $display("FAIL sat_hold got %h want ffff", stall_cycles);
        end
        set_in(0, 0, 0, 0);
    endtask

    task automatic test_rst_mid_drain();
        do_rst();
        set_in(0, 0, 1, 0);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0);
        #1;
        tests++;
        if (en !== 5'b01101) begin
            failed++;
            $display("FAIL mid_drain_en got %b want 01101", en);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (en !== 5'b00000 || halted !== 1'b0) begin
            failed++;
            $display("FAIL mid_rst got en=%b h=%b want 00000 h=0",
                     en, halted);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (en !== 5'b11001) begin
            failed++;
            $display("FAIL post_rst_en got %b want 11001", en);
        end
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (halted !== 1'b0 || en !== 5'b11001) begin
            failed++;
            $display("FAIL post_rst_run got h=%b en=%b want h=0 11001",
                     halted, en);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        set_in(0, 0, 0, 0);
        test_reset();
        test_idle();
        test_stall_branch();
        test_watchdog();
        test_halt();
        test_busy_priority();
        test_rst_mid_drain();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
